// File: rtl/code_store_responder_if.sv
// ---------------------------------------------------------------------------
// code_store_responder_if
//
// Strobe and status signals shared between a core's code loader (master) and
// the fabric-side code store (slave). The four data lanes are tri-stated and
// shared by both ends, so they stay as plain inout ports on the responder.
//
// Signals:
//   ADDRFD            master -> slave  address strobe, one cycle
//   READFD            master -> slave  read strobe, one cycle per word
//   WRITEFD           master -> slave  write strobe, one cycle per word
//   BUSY_line_MASTER  master -> slave  transaction held open while high
//   SEL               fabric -> slave  grant for this responder
//   BUSY_line_SLAVE   slave  -> master responder is processing a strobe
//   ERR               slave  -> master sticky protocol-error flag
// ---------------------------------------------------------------------------
interface code_store_responder_if;
  logic ADDRFD;
  logic READFD;
  logic WRITEFD;
  logic BUSY_line_MASTER;
  logic SEL;
  logic BUSY_line_SLAVE;
  logic ERR;

  modport master (
    output ADDRFD, READFD, WRITEFD, BUSY_line_MASTER, SEL,
    input  BUSY_line_SLAVE, ERR
  );

  modport slave (
    input  ADDRFD, READFD, WRITEFD, BUSY_line_MASTER, SEL,
    output BUSY_line_SLAVE, ERR
  );
endinterface

// File: rtl/code_store_responder.sv
// ---------------------------------------------------------------------------
// code_store_responder
//
// Fabric-side code memory. An address strobe opens a burst (start address and
// word count taken from the lanes); each read or write strobe then moves one
// command word and advances the address, wrapping at the end of the array.
//
// Parameters:
//   SEG_W   width of one data lane; a command word is 4*SEG_W bits
//   ADDR_W  address width, array depth 2**ADDR_W (ADDR_W must be <= SEG_W)
//
// Ports:
//   CLK_B                   bus clock, rising edge
//   RESET                   asynchronous, active-low
//   SA_D3, SB_D2, SC_D1, IP_D0  inout data lanes, word = {SA_D3,SB_D2,SC_D1,IP_D0}
//   bus                     code_store_responder_if.slave strobes/status
//   LOCK                    (only with CODESTORE_LOCK_EN) write-protect input
//
// Build option:
//   CODESTORE_LOCK_EN  adds LOCK; locked writes still advance the burst and
//                      pulse BUSY_line_SLAVE but leave memory untouched and
//                      raise ERR.
// ---------------------------------------------------------------------------
module code_store_responder #(
  parameter int SEG_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic               CLK_B,
  input  logic               RESET,
  inout  wire  [SEG_W-1:0]   SA_D3,
  inout  wire  [SEG_W-1:0]   SB_D2,
  inout  wire  [SEG_W-1:0]   SC_D1,
  inout  wire  [SEG_W-1:0]   IP_D0,
`ifdef CODESTORE_LOCK_EN
  input  logic               LOCK,
`endif
  code_store_responder_if.slave bus
);

  localparam int WORD_W = 4 * SEG_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int CNT_W  = SEG_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RD_FETCH,
    RD_DRIVE,
    WR_COMMIT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   adr;
  logic [CNT_W-1:0]    cnt;
  logic                err;
  logic                wr_block;
  logic [WORD_W-1:0]   wr_data;
  logic [WORD_W-1:0]   rd_data;
  logic [WORD_W-1:0]   mem [DEPTH];

  logic [WORD_W-1:0]   lane_word;
  logic                lock_now;
  logic                lane_drive;
  logic                capture;
  logic                fetch;
  logic                commit;
  logic                take_wr;
  logic                err_set;

  assign lane_word = {SA_D3, SB_D2, SC_D1, IP_D0};

`ifdef CODESTORE_LOCK_EN
  assign lock_now = LOCK;
`else
  assign lock_now = 1'b0;
`endif

  // Next-state and strobe decode. Protocol errors are flagged independently
  // of the state move so an ignored strobe still leaves a trace in ERR.
  // A dropped BUSY_line_MASTER overrides everything, so a write strobe in
  // that cycle is never captured and nothing commits.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    fetch      = 1'b0;
    commit     = 1'b0;
    take_wr    = 1'b0;
    err_set    = 1'b0;

    if (bus.READFD && bus.WRITEFD)
      err_set = 1'b1;
    if (bus.ADDRFD && state != IDLE)
      err_set = 1'b1;
    if (state == IDLE && (bus.READFD || bus.WRITEFD))
      err_set = 1'b1;

    if (!bus.BUSY_line_MASTER) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ADDRFD && bus.SEL) begin
            capture    = 1'b1;
            state_next = ARMED;
          end
        end
        ARMED, RD_DRIVE: begin
          if (state == RD_DRIVE && cnt == '0) begin
            // burst exhausted: hold the last word until the master lets go
            if (bus.READFD || bus.WRITEFD)
              err_set = 1'b1;
          end else if (!(bus.READFD && bus.WRITEFD)) begin
            if (bus.READFD) begin
              state_next = RD_FETCH;
            end else if (bus.WRITEFD) begin
              take_wr    = 1'b1;
              state_next = WR_COMMIT;
            end
          end
        end
        RD_FETCH: begin
          fetch      = 1'b1;
          state_next = RD_DRIVE;
        end
        WR_COMMIT: begin
          commit     = 1'b1;
          state_next = (cnt == CNT_W'(1)) ? IDLE : ARMED;
        end
        default: state_next = IDLE;
      endcase
    end

    if (take_wr && lock_now)
      err_set = 1'b1;
  end

  // State register; reset returns to IDLE immediately, which also releases
  // the lanes and drops BUSY_line_SLAVE without waiting for a clock.
  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Burst address/count and the sticky error flag. The count holds one more
  // than the lane value, so a lane value of 0 still moves one word.
  always_ff @(posedge CLK_B or negedge RESET) begin
    if (!RESET) begin
      adr      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      wr_block <= 1'b0;
    end else begin
      if (err_set)
        err <= 1'b1;
      if (capture) begin
        adr <= IP_D0[ADDR_W-1:0];
        cnt <= CNT_W'(SC_D1) + CNT_W'(1);
      end else if (fetch || commit) begin
        adr <= adr + ADDR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
      if (take_wr)
        wr_block <= lock_now;
    end
  end

  // Array and data holding registers; memory contents survive reset.
  always_ff @(posedge CLK_B) begin
    if (take_wr)
      wr_data <= lane_word;
    if (fetch)
      rd_data <= mem[adr];
    if (commit && !wr_block)
      mem[adr] <= wr_data;
  end

  assign lane_drive = (state == RD_DRIVE);

  assign SA_D3 = lane_drive ? rd_data[4*SEG_W-1:3*SEG_W] : {SEG_W{1'bz}};
  assign SB_D2 = lane_drive ? rd_data[3*SEG_W-1:2*SEG_W] : {SEG_W{1'bz}};
  assign SC_D1 = lane_drive ? rd_data[2*SEG_W-1:SEG_W]   : {SEG_W{1'bz}};
  assign IP_D0 = lane_drive ? rd_data[SEG_W-1:0]         : {SEG_W{1'bz}};

  assign bus.BUSY_line_SLAVE = (state == RD_FETCH) || (state == WR_COMMIT);
  assign bus.ERR             = err;

endmodule
